// File: rtl/dmp_pkg.sv
// Shared types and constants for the deterministic update arbiter.
package dmp_pkg;

    localparam int DMP_ID_W   = 32;
    localparam int DMP_DATA_W = 32;
    localparam int EPOCH_W    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } dmp_state_t;

    typedef struct packed {
        logic [DMP_ID_W-1:0]   dest;
        logic [DMP_DATA_W-1:0] data;
    } dmp_update_t;

    function automatic logic [EPOCH_W-1:0] epoch_sat_inc(input logic [EPOCH_W-1:0] v);
        return (v == {EPOCH_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmp_sync_fifo.sv
// Single-clock FIFO holding one thread's remote updates; DEPTH must be a power of 2.
module dmp_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_dout    = r_mem[r_rd];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/dmp_arbiter.sv
// Routes scatter updates: owned destinations bypass locally, the rest are
// buffered per thread and drained in fixed thread-index order.
module dmp_arbiter
    import dmp_pkg::*;
#(
    parameter int NUM_HW_THREADS = 8,
    parameter int DATA_W         = 32,
    parameter int ID_W           = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              next_iteration,
    input  logic                              serial_all,
    input  logic [ID_W-1:0]                   part_base   [NUM_HW_THREADS],
    input  logic [ID_W-1:0]                   part_size   [NUM_HW_THREADS],
    input  logic                              in_valid    [NUM_HW_THREADS],
    input  logic [ID_W-1:0]                   in_dest     [NUM_HW_THREADS],
    input  logic [DATA_W-1:0]                 in_data     [NUM_HW_THREADS],
    output logic                              in_ready    [NUM_HW_THREADS],
    input  logic                              thread_done [NUM_HW_THREADS],
    output logic                              loc_valid   [NUM_HW_THREADS],
    output logic [ID_W-1:0]                   loc_dest    [NUM_HW_THREADS],
    output logic [DATA_W-1:0]                 loc_data    [NUM_HW_THREADS],
    output logic                              ser_valid,
    input  logic                              ser_ready,
    output logic [$clog2(NUM_HW_THREADS)-1:0] ser_tid,
    output logic [ID_W-1:0]                   ser_dest,
    output logic [DATA_W-1:0]                 ser_data,
    output logic                              op_complete,
    output logic [EPOCH_W-1:0]                epoch_count
);
    localparam int TID_W = $clog2(NUM_HW_THREADS);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int UW    = ID_W + DATA_W;

    dmp_state_t              r_state;
    logic [NUM_HW_THREADS-1:0] r_done_seen;
    logic                    r_serial_all;
    logic [EPOCH_W-1:0]      r_epoch;

    logic [NUM_HW_THREADS-1:0] w_td;
    logic [NUM_HW_THREADS-1:0] w_full;
    logic [NUM_HW_THREADS-1:0] w_empty;
    logic [NUM_HW_THREADS-1:0] w_full_nxt;
    logic [NUM_HW_THREADS-1:0] w_empty_nxt;
    logic [NUM_HW_THREADS-1:0] w_pop;
    logic [CW-1:0]           w_count [NUM_HW_THREADS];
    logic [UW-1:0]           w_dout  [NUM_HW_THREADS];
    logic [TID_W-1:0]        w_sel;
    logic                    w_found;

    for (genvar g = 0; g < NUM_HW_THREADS; g++) begin : g_thr
        logic [ID_W:0]     w_lo;
        logic [ID_W:0]     w_hi;
        logic [ID_W:0]     w_d;
        logic              w_own;
        logic              w_accept;
        logic              w_is_loc;
        logic              w_push;
        logic              r_loc_valid;
        logic [ID_W-1:0]   r_loc_dest;
        logic [DATA_W-1:0] r_loc_data;

        // One extra bit so base+size never wraps past the ID space.
        assign w_lo     = {1'b0, part_base[g]};
        assign w_hi     = w_lo + {1'b0, part_size[g]};
        assign w_d      = {1'b0, in_dest[g]};
        assign w_own    = (w_d >= w_lo) && (w_d < w_hi);
        assign w_accept = (r_state == COLLECT) && in_valid[g] && !w_full[g];
        assign w_is_loc = w_own && !r_serial_all;
        assign w_push   = w_accept && !w_is_loc;
        assign w_pop[g] = (r_state == DRAIN) && w_found && ser_ready && (w_sel == TID_W'(g));

        assign w_full_nxt[g]  = w_full[g] || (w_push && (w_count[g] == CW'(FIFO_DEPTH - 1)));
        assign w_empty_nxt[g] = w_empty[g] || (w_pop[g] && (w_count[g] == CW'(1)));
        assign w_td[g]        = thread_done[g];
        assign in_ready[g]    = (r_state == COLLECT) && !w_full[g];
        assign loc_valid[g]   = r_loc_valid;
        assign loc_dest[g]    = r_loc_dest;
        assign loc_data[g]    = r_loc_data;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_loc_valid <= 1'b0;
                r_loc_dest  <= '0;
                r_loc_data  <= '0;
            end else begin
                r_loc_valid <= w_accept && w_is_loc;
                r_loc_dest  <= (w_accept && w_is_loc) ? in_dest[g] : '0;
                r_loc_data  <= (w_accept && w_is_loc) ? in_data[g] : '0;
            end
        end

        dmp_sync_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (UW)
        ) u_fifo (
            .i_clk   (clock),
            .i_rst   (reset),
            .i_push  (w_push),
            .i_din   ({in_dest[g], in_data[g]}),
            .i_pop   (w_pop[g]),
            .o_dout  (w_dout[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_count (w_count[g])
        );
    end

    // Lowest-index non-empty FIFO wins; no pushes occur while draining,
    // so each thread empties fully before the next is selected.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int t = NUM_HW_THREADS - 1; t >= 0; t--) begin
            if (!w_empty[t]) begin
                w_sel   = TID_W'(t);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        ser_valid = (r_state == DRAIN) && w_found;
        ser_tid   = ser_valid ? w_sel : '0;
        ser_dest  = '0;
        ser_data  = '0;
        if (ser_valid) {ser_dest, ser_data} = w_dout[w_sel];
    end

    assign op_complete = (r_state == DONE);
    assign epoch_count = r_epoch;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_done_seen  <= '0;
            r_serial_all <= 1'b0;
            r_epoch      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_serial_all <= serial_all;
                    if (start) r_state <= COLLECT;
                end
                COLLECT: begin
                    r_done_seen <= r_done_seen | w_td;
                    if ((|w_full_nxt) || (&(r_done_seen | w_td))) r_state <= DRAIN;
                end
                DRAIN: begin
                    // Exit on the cycle of the final pop so DONE follows immediately.
                    if (&w_empty_nxt) begin
                        r_epoch <= epoch_sat_inc(r_epoch);
                        r_state <= (&r_done_seen) ? DONE : COLLECT;
                    end
                end
                DONE: begin
                    r_serial_all <= serial_all;
                    if (next_iteration) begin
                        r_done_seen <= '0;
                        r_epoch     <= '0;
                        r_state     <= COLLECT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmp_arbiter.md
# dmp_arbiter

Parametrised deterministic update arbiter between the scatter threads and the pagerank update engine.

- Updates whose destination lies in the issuing thread's own partition bypass to a per-thread local port.
- All other updates are buffered per thread, then serialised in fixed thread-index order. Results are bit-identical regardless of thread timing.
- Supports configurable thread count, data/ID widths and FIFO depth, plus a runtime all-serial mode.

## Interface

Parameters:
- NUM_HW_THREADS, 8, number of scatter threads/partitions
- DATA_W, 32, fixed-point pagerank contribution width
- ID_W, 32, node ID width
- FIFO_DEPTH, 4, per-thread remote-update buffer depth (≥2, power of 2)

Ports (clock domain: one clock; reset is synchronous and active-high):
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  leave IDLE, begin first epoch
- next_iteration  in  1  leave DONE, begin new iteration
- serial_all  in  1  1: every update takes the serial path; sampled only in IDLE/DONE
- part_base[NUM_HW_THREADS]  in  ID_W  first node ID owned by thread t
- part_size[NUM_HW_THREADS]  in  ID_W  node count owned by thread t
- in_valid[NUM_HW_THREADS]  in  1  scatter update offered
- in_dest[NUM_HW_THREADS]  in  ID_W  destination node
- in_data[NUM_HW_THREADS]  in  DATA_W  contribution
- in_ready[NUM_HW_THREADS]  out  1  update accepted when in_valid & in_ready
- thread_done[NUM_HW_THREADS]  in  1  thread finished scatter for this iteration
- loc_valid[NUM_HW_THREADS]  out  1  local update strobe
- loc_dest[NUM_HW_THREADS]  out  ID_W  local destination
- loc_data[NUM_HW_THREADS]  out  DATA_W  local contribution
- ser_valid  out  1  serial update offered
- ser_ready  in  1  update engine accepts serial update
- ser_tid  out  $clog2(NUM_HW_THREADS)  originating thread
- ser_dest  out  ID_W  destination
- ser_data  out  DATA_W  contribution
- op_complete  out  1  iteration finished
- epoch_count  out  16  drain epochs completed this iteration

## Operation

- States: IDLE, COLLECT, DRAIN, DONE. Reset → IDLE.
- IDLE → COLLECT on start.
- COLLECT:
  - in_ready[t] = !fifo_full[t].
  - Accepted update is local iff part_base[t] ≤ dest < part_base[t]+part_size[t] (ID_W+1-bit compare, no wrap) and serial_all latched 0.
  - Local updates drive loc_* the next cycle for one cycle. Remote updates push into FIFO t.
  - thread_done[t] sets sticky done_seen[t]. An update and done in the same cycle: the update is accepted and done is recorded.
- COLLECT → DRAIN when any FIFO is full at the cycle end, or when all done_seen are set.
- DRAIN:
  - in_ready all 0.
  - Emit the head of the lowest-index non-empty FIFO. Pop on ser_valid & ser_ready.
  - Thread t drains completely before thread t+1.
  - ser_* hold stable while ser_valid & !ser_ready.
- DRAIN exit, when all FIFOs are empty:
  - epoch_count increments (saturating at 0xFFFF).
  - Go to DONE if all done_seen are set, else back to COLLECT.
- DONE:
  - op_complete=1, in_ready all 0.
  - On next_iteration: clear done_seen and epoch_count, latch serial_all, go to COLLECT.
- Reset at any time: FIFOs flushed, done_seen cleared, state IDLE, in-flight data discarded.

## Timing

- Every output resets to 0, and is 0 in IDLE. ser_tid/dest/data are 0 when ser_valid=0.
- Local path latency: 1 cycle from acceptance to loc_valid.
- Serial path: first ser_valid appears 1 cycle after entering DRAIN. With ser_ready held high, throughput is 1 entry per cycle.
- FIFO full→DRAIN: the cycle of the filling push is the last accept cycle. in_ready drops the next cycle.
- Zero updates with all done: COLLECT→DRAIN→DONE in 2 cycles, epoch_count=1.
- op_complete asserts the cycle after the final pop and stays high until next_iteration.

## Structure

- Package dmp_pkg holds:
  - dmp_state_t enum.
  - dmp_update_t struct {dest, data}, parametrised via localparams or package-width defaults.
  - the saturating epoch counter width constant.
- Sub-module dmp_sync_fifo (DEPTH, WIDTH; push/pop/full/empty/count, synchronous active-high reset), instantiated once per thread via generate.
- The top level holds the FSM, ownership compare, fixed-priority drain selector and local output registers.

## Test plan

- Local bypass: 4 threads, part_base={0,8,16,24}, size 8. Thread 1 sends dest 10, data 0x55 → loc_valid[1] one cycle later with 10/0x55, no ser_valid.
- Deterministic order: threads 3,0,2 each push one remote update in cycle order 3,0,2, then all done → ser_tid sequence 0,2,3, then op_complete.
- Full-triggered drain: FIFO_DEPTH=2, thread 0 sends 2 remote updates → in_ready[0] low, DRAIN, 2 serial beats, back to COLLECT, epoch_count=1.
- Backpressure: ser_ready=0 for 3 cycles mid-drain → ser_* stable, no loss, order preserved.
- serial_all=1 at IDLE: owned dest 3 from thread 0 → appears on ser_* only, loc_valid stays 0.
- Reset mid-DRAIN with 3 queued → next cycle all outputs 0, state IDLE. After start plus all done → op_complete with zero serial beats.
